// File: rtl/motion_cntrl_pkg.sv
// Shared types, sequencing constants and saturation helpers for the
// line-follower steering controller.
package motion_cntrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    CONV     = 3'd2,
    WAIT     = 3'd3,
    ACCUM    = 3'd4,
    CALC_I   = 3'd5,
    CALC_OUT = 3'd6
  } state_t;

  localparam int NUM_CONV = 6;

  // Conversion order: right then left sensor of each pair, inner pair first.
  localparam logic [2:0] CHNL_SEQ [NUM_CONV] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  // Signed steering weight applied to each conversion in the order above.
  localparam logic signed [3:0] CHNL_WEIGHT [NUM_CONV] =
    '{4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd4, -4'sd4};

  // Emitter select per pair index {out, mid, in}; the last entry is a safe all-off.
  localparam logic [2:0] PAIR_EN [4] = '{3'b001, 3'b010, 3'b100, 3'b000};

  localparam int                SETTLE_CYCLES_DEF = 4096;
  localparam int                P_TERM_DEF        = 4;
  localparam int                I_SHIFT_DEF       = 2;
  localparam logic signed [10:0] FWD_DEF          = 11'sh200;

  function automatic logic signed [11:0] sat12(input logic signed [16:0] v);
    if (v > 17'sd2047)
      return 12'sh7FF;
    else if (v < -17'sd2048)
      return 12'sh800;
    else
      return v[11:0];
  endfunction

  function automatic logic signed [10:0] sat11(input logic signed [16:0] v);
    if (v > 17'sd1023)
      return 11'sh3FF;
    else if (v < -17'sd1024)
      return 11'sh400;
    else
      return v[10:0];
  endfunction

endpackage

// File: rtl/pi_calc.sv
// Combinational PI steering math: error saturation, integrator update and
// left/right duty computation. All results are registered by the parent.
module pi_calc
  import motion_cntrl_pkg::*;
#(
  parameter int                P_TERM  = P_TERM_DEF,
  parameter int                I_SHIFT = I_SHIFT_DEF,
  parameter logic signed [10:0] FWD    = FWD_DEF
) (
  input  logic signed [15:0] accum,
  input  logic signed [11:0] error,
  input  logic signed [11:0] intgrl,
  output logic signed [11:0] error_nxt,
  output logic signed [11:0] intgrl_nxt,
  output logic signed [10:0] lft_nxt,
  output logic signed [10:0] rht_nxt
);

  localparam logic [3:0] P_GAIN = 4'(P_TERM);

  logic signed [11:0] err_shift;
  logic signed [16:0] intgrl_sum;
  logic signed [15:0] pcomp;
  logic signed [16:0] steer;
  logic signed [16:0] fwd_ext;

  // Integrator uses the freshly saturated error; duties use the registered error/integrator.
  always_comb begin
    error_nxt  = sat12(17'(accum));
    err_shift  = error_nxt >>> I_SHIFT;
    intgrl_sum = 17'(intgrl) + 17'(err_shift);
    intgrl_nxt = sat12(intgrl_sum);
    pcomp      = 16'(error) * $signed({12'd0, P_GAIN});
    steer      = 17'(pcomp) + 17'(intgrl);
    fwd_ext    = 17'(FWD);
    lft_nxt    = sat11(fwd_ext - steer);
    rht_nxt    = sat11(fwd_ext + steer);
  end

endmodule

// File: rtl/motion_controller.sv
// Line-follower steering controller: sequences six IR conversions per control
// cycle, accumulates a weighted error and drives saturated PI motor duties.
module motion_controller
  import motion_cntrl_pkg::*;
#(
  parameter int                SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int                P_TERM        = P_TERM_DEF,
  parameter int                I_SHIFT       = I_SHIFT_DEF,
  parameter logic signed [10:0] FWD          = FWD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               cnv_cmplt,
  input  logic [11:0]        A2D_res,
  output logic               start_conv,
  output logic [2:0]         chnnl,
  output logic               IR_in_en,
  output logic               IR_mid_en,
  output logic               IR_out_en,
  output logic [7:0]         LEDs,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht
);

  localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic [2:0]         pair_en;

  logic [11:0]        res_p0;
  logic signed [15:0] wprod;
  logic signed [15:0] accum;
  logic signed [11:0] error, intgrl;
  logic signed [11:0] error_nxt, intgrl_nxt;
  logic signed [10:0] lft_nxt, rht_nxt;

  assign IR_in_en  = pair_en[0];
  assign IR_mid_en = pair_en[1];
  assign IR_out_en = pair_en[2];

  // Weighted contribution of the captured conversion result (result is zero-extended).
  assign wprod = 16'(CHNL_WEIGHT[idx]) * $signed({4'd0, res_p0});

  pi_calc #(
    .P_TERM  (P_TERM),
    .I_SHIFT (I_SHIFT),
    .FWD     (FWD)
  ) u_pi_calc (
    .accum      (accum),
    .error      (error),
    .intgrl     (intgrl),
    .error_nxt  (error_nxt),
    .intgrl_nxt (intgrl_nxt),
    .lft_nxt    (lft_nxt),
    .rht_nxt    (rht_nxt)
  );

  // Control state register: sequencer state, conversion index and settle counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // Next-state logic plus the conversion strobe and the current pair's emitter enable.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    start_conv     = 1'b0;
    pair_en        = 3'b000;
    case (state)
      IDLE: begin
        idx_nxt        = '0;
        settle_cnt_nxt = '0;
        state_nxt      = SETTLE;
      end
      SETTLE: begin
        pair_en = PAIR_EN[idx[2:1]];
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nxt = '0;
          state_nxt      = CONV;
        end else begin
          settle_cnt_nxt = settle_cnt + 1'b1;
        end
      end
      CONV: begin
        pair_en    = PAIR_EN[idx[2:1]];
        start_conv = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        pair_en = PAIR_EN[idx[2:1]];
        if (cnv_cmplt)
          state_nxt = ACCUM;
      end
      ACCUM: begin
        pair_en = PAIR_EN[idx[2:1]];
        if (!idx[0]) begin
          // Second sensor of the same pair: emitters are already settled.
          idx_nxt   = idx + 3'd1;
          state_nxt = CONV;
        end else if (idx == 3'(NUM_CONV - 1)) begin
          state_nxt = CALC_I;
        end else begin
          idx_nxt        = idx + 3'd1;
          settle_cnt_nxt = '0;
          state_nxt      = SETTLE;
        end
      end
      CALC_I: begin
        state_nxt = CALC_OUT;
      end
      CALC_OUT: begin
        idx_nxt        = '0;
        settle_cnt_nxt = '0;
        state_nxt      = SETTLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!go) begin
      state_nxt      = IDLE;
      idx_nxt        = '0;
      settle_cnt_nxt = '0;
    end
  end

  // Datapath: capture result, accumulate, PI update and registered motor/LED outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      res_p0 <= '0;
      accum  <= '0;
      error  <= '0;
      intgrl <= '0;
      lft    <= '0;
      rht    <= '0;
      LEDs   <= '0;
      chnnl  <= '0;
    end else if (!go) begin
      // Integrator survives a pause; everything else returns to idle values.
      accum <= '0;
      lft   <= '0;
      rht   <= '0;
      LEDs  <= '0;
      chnnl <= '0;
    end else begin
      case (state)
        IDLE:     accum <= '0;
        WAIT:     if (cnv_cmplt) res_p0 <= A2D_res;
        ACCUM:    accum <= accum + wprod;
        CALC_I: begin
          error  <= error_nxt;
          intgrl <= intgrl_nxt;
        end
        CALC_OUT: begin
          lft   <= lft_nxt;
          rht   <= rht_nxt;
          LEDs  <= error[11:4];
          accum <= '0;
        end
        default: ;
      endcase
      if (state_nxt == CONV)
        chnnl <= CHNL_SEQ[idx_nxt];
    end
  end

endmodule

// File: tb/tb_motion_controller.sv
// Bench for motion_controller: directed vector table, randomized cycles against
// an arithmetic reference model, and go-drop / mid-run reset sequences.
module tb_motion_controller;

  localparam int SETTLE = 16;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        start_conv;
  logic [2:0]  chnnl;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic [7:0]  LEDs;
  logic [10:0] lft, rht;

  int checks   = 0;
  int failures = 0;

  logic [11:0] vals [8];
  int lat_min = 0;
  int lat_max = 0;
  int m_intgrl = 0;
  int ch_weight [8] = '{-1, 1, -2, 4, 2, 0, 0, -4};

  typedef struct {
    int          ch;      // 8 = every channel
    logic [11:0] val;
    logic [10:0] e_lft;
    logic [10:0] e_rht;
    logic [7:0]  e_leds;
    int          reps;
  } vec_t;

  always #5 clk = ~clk;

  motion_controller #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .cnv_cmplt  (cnv_cmplt),
    .A2D_res    (A2D_res),
    .start_conv (start_conv),
    .chnnl      (chnnl),
    .IR_in_en   (IR_in_en),
    .IR_mid_en  (IR_mid_en),
    .IR_out_en  (IR_out_en),
    .LEDs       (LEDs),
    .lft        (lft),
    .rht        (rht)
  );

  // A2D model: answers each start_conv with the value for the selected channel.
  initial begin
    int lat;
    cnv_cmplt = 1'b0;
    A2D_res   = 12'h000;
    forever begin
      @(negedge clk);
      if (start_conv === 1'b1) begin
        A2D_res = vals[chnnl];
        lat = int'($urandom_range(lat_max, lat_min));
        if (lat > 0) begin
          cnv_cmplt = 1'b0;
          repeat (lat) @(negedge clk);
        end
        cnv_cmplt = 1'b1;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_cycle(output int e_lft, output int e_rht, output int e_leds);
    int acc, err, sh, steer;
    acc = 0;
    for (int c = 0; c < 8; c++) acc += ch_weight[c] * int'(vals[c]);
    err = clampi(acc, -2048, 2047);
    sh = (err >= 0) ? err / 4 : -((-err + 3) / 4);
    m_intgrl = clampi(m_intgrl + sh, -2048, 2047);
    steer = err * 4 + m_intgrl;
    e_lft  = clampi(512 - steer, -1024, 1023) & 32'h7FF;
    e_rht  = clampi(512 + steer, -1024, 1023) & 32'h7FF;
    e_leds = (err & 32'hFFF) >> 4;
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (start_conv !== 1'b1 && n < BUDGET);
    if (start_conv !== 1'b1) begin
      checks++;
      failures++;
      ok = 1'b0;
      $display("FAIL wait_start: no start_conv within %0d cycles", BUDGET);
    end
  endtask

  // One full control cycle: checks channel order, enables, latency and the model result.
  task automatic run_cycle(input bit first_seen, output logic [10:0] o_lft,
                           output logic [10:0] o_rht, output logic [7:0] o_leds);
    int          seq [6]    = '{1, 0, 4, 2, 3, 7};
    logic [2:0]  en_exp [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    bit ok;
    int n, e_lft, e_rht, e_leds;
    o_lft  = '0;
    o_rht  = '0;
    o_leds = '0;
    for (int k = 0; k < 6; k++) begin
      if (!(first_seen && k == 0)) begin
        wait_start(ok);
        if (!ok) return;
      end
      check("chnnl_order", 32'(chnnl), 32'(seq[k]));
      check("pair_enable", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'(en_exp[k]));
    end
    n = 0;
    while (IR_out_en === 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("calc_i_enables", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'd0);
    @(negedge clk);
    check("calc_out_enables", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'd0);
    @(negedge clk);
    check("resettle_in_en", 32'(IR_in_en), 32'd1);
    model_cycle(e_lft, e_rht, e_leds);
    check("model_lft", 32'(lft), 32'(e_lft));
    check("model_rht", 32'(rht), 32'(e_rht));
    check("model_leds", 32'(LEDs), 32'(e_leds));
    o_lft  = lft;
    o_rht  = rht;
    o_leds = LEDs;
  endtask

  initial begin
    vec_t        tbl [5];
    logic [10:0] a_lft, a_rht;
    logic [7:0]  a_leds;
    int          sc_cnt, nz, n;
    bit          ok;

    tbl[0] = '{8, 12'hAAA, 11'h200, 11'h200, 8'h00, 1};
    tbl[1] = '{1, 12'h100, 11'h5C0, 11'h3FF, 8'h10, 1};
    tbl[2] = '{7, 12'hFFF, 11'h3FF, 11'h400, 8'h80, 1};
    tbl[3] = '{1, 12'h100, 11'h400, 11'h3FF, 8'h10, 40};
    tbl[4] = '{0, 12'h190, 11'h0A5, 11'h35B, 8'hE7, 1};

    rst_n = 1'b1;
    go    = 1'b0;
    for (int c = 0; c < 8; c++) vals[c] = 12'h000;
    repeat (5) @(negedge clk);
    check("rst_start_conv", 32'(start_conv), 32'd0);
    check("rst_chnnl", 32'(chnnl), 32'd0);
    check("rst_enables", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'd0);
    check("rst_leds", 32'(LEDs), 32'd0);
    check("rst_lft", 32'(lft), 32'd0);
    check("rst_rht", 32'(rht), 32'd0);

    // Released with go low: must sit quietly in idle.
    rst_n  = 1'b0;
    sc_cnt = 0;
    nz     = 0;
    repeat (10000) begin
      @(negedge clk);
      if (start_conv !== 1'b0) sc_cnt++;
      if ({lft, rht, LEDs, chnnl, IR_out_en, IR_mid_en, IR_in_en} !== '0) nz++;
    end
    check("idle_start_conv_count", 32'(sc_cnt), 32'd0);
    check("idle_nonzero_outputs", 32'(nz), 32'd0);

    // Directed vector table with instant conversions.
    lat_min = 0;
    lat_max = 0;
    go = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 8; c++)
        vals[c] = (tbl[t].ch == 8 || tbl[t].ch == c) ? tbl[t].val : 12'h000;
      for (int r = 0; r < tbl[t].reps; r++) run_cycle(1'b0, a_lft, a_rht, a_leds);
      check($sformatf("tbl%0d_lft", t), 32'(a_lft), 32'(tbl[t].e_lft));
      check($sformatf("tbl%0d_rht", t), 32'(a_rht), 32'(tbl[t].e_rht));
      check($sformatf("tbl%0d_leds", t), 32'(a_leds), 32'(tbl[t].e_leds));
    end

    // Randomized readings and conversion latency against the model.
    lat_min = 0;
    lat_max = 6;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 8; c++)
        vals[c] = 12'($urandom_range(0, (r % 2 == 1) ? 4095 : 300));
      run_cycle(1'b0, a_lft, a_rht, a_leds);
    end

    // Drop go while waiting on a slow conversion.
    lat_min = 8;
    lat_max = 8;
    wait_start(ok);
    @(negedge clk);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("drop_enables", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'd0);
    check("drop_start_conv", 32'(start_conv), 32'd0);
    check("drop_lft", 32'(lft), 32'd0);
    check("drop_rht", 32'(rht), 32'd0);
    repeat (3) @(negedge clk);
    check("drop_chnnl", 32'(chnnl), 32'd0);
    check("drop_leds", 32'(LEDs), 32'd0);

    // Re-raise go: first conversion after a full settle, integrator retained.
    lat_min = 0;
    lat_max = 3;
    for (int c = 0; c < 8; c++) vals[c] = 12'($urandom_range(0, 400));
    go = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (start_conv !== 1'b1 && n < BUDGET);
    check("restart_latency", 32'(n), 32'(SETTLE + 1));
    run_cycle(1'b1, a_lft, a_rht, a_leds);

    // Reset in the middle of operation with go held high.
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_lft", 32'(lft), 32'd0);
    check("midrst_rht", 32'(rht), 32'd0);
    check("midrst_leds", 32'(LEDs), 32'd0);
    check("midrst_chnnl", 32'(chnnl), 32'd0);
    check("midrst_enables", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'd0);
    check("midrst_start_conv", 32'(start_conv), 32'd0);
    @(negedge clk);
    m_intgrl = 0;
    for (int c = 0; c < 8; c++) vals[c] = (c == 1) ? 12'h100 : 12'h000;
    lat_min = 0;
    lat_max = 0;
    rst_n = 1'b0;
    run_cycle(1'b0, a_lft, a_rht, a_leds);
    check("postrst_lft", 32'(a_lft), 32'h5C0);
    check("postrst_rht", 32'(a_rht), 32'h3FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_controller.md
# motion_controller

Line-follower steering controller between the A2D/SPI front end and the motor PWM drivers. It sequences six IR sensor readings per control cycle and forms a weighted left/right error. A saturating PI law then produces signed left/right motor duty commands. Runs continuously while `go` is high.

## Interface
- `SETTLE_CYCLES`, 4096: clocks an IR emitter pair is enabled before its first conversion.
- `P_TERM`, 4: unsigned proportional multiplier (4 bits).
- `I_SHIFT`, 2: arithmetic right shift applied to Error before integration.
- `FWD`, 11'h200: signed forward duty baseline.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: **synchronous, active-high reset** (port keeps the codebase name; polarity and synchronicity fixed as active-high synchronous).
- `go` in 1: run enable.
- `cnv_cmplt` in 1: A2D conversion done (level).
- `A2D_res` in 12: unsigned conversion result.
- `start_conv` out 1: one-cycle conversion request.
- `chnnl` out 3: A2D channel select.
- `IR_in_en`, `IR_mid_en`, `IR_out_en` out 1 each: IR emitter pair enables.
- `LEDs` out 8: Error[11:4].
- `lft`, `rht` out 11: signed motor duty commands.

## Operation
- Channel sequence per cycle, with signed weight and enable:
  - ch1 +1 and ch0 −1, `IR_in_en`.
  - ch4 +2 and ch2 −2, `IR_mid_en`.
  - ch3 +4 and ch7 −4, `IR_out_en`.
- Accum is 16-bit signed. It is cleared at the start of each control cycle. After each conversion, Accum += weight × A2D_res (zero-extended).
- States:
  - IDLE: go=1 → SETTLE with the first pair.
  - SETTLE: the pair's enable is high; counts SETTLE_CYCLES clocks → CONV.
  - CONV: `start_conv`=1 for this one cycle → WAIT.
  - WAIT: on `cnv_cmplt`=1 → ACCUM.
  - ACCUM: add the weighted result. After the right channel of a pair → CONV for the left channel (no re-settle). After the left channel → SETTLE for the next pair. After ch7 → CALC_I.
  - CALC_I: Error = sat12(Accum); Intgrl = sat12(Intgrl + (Error >>> I_SHIFT)) → CALC_OUT.
  - CALC_OUT: Pcomp = Error × P_TERM (16-bit signed); steer = Pcomp + Intgrl (17-bit); lft = sat11(FWD − steer); rht = sat11(FWD + steer); LEDs update. Then → SETTLE with the first pair and Accum cleared.
- Only the current pair's enable is high, and only from SETTLE through that pair's second ACCUM. All enables are low in IDLE, CALC_I and CALC_OUT.
- `chnnl` is set on entry to CONV and held until the next channel.
- Saturation: satN clamps to [−2^(N−1), 2^(N−1)−1].

## Timing
- Reset, and go=0 while in IDLE, give:
  - all outputs 0 (`chnnl`=0, `LEDs`=0, `lft`=`rht`=0);
  - Accum=0, Intgrl=0, state IDLE.
- go falling in any state: the next clock enters IDLE, clears enables, `start_conv`, `lft` and `rht`, and clears Accum. Intgrl is kept.
- Reset mid-operation: identical to the reset values, next clock.
- `cnv_cmplt` is ignored outside WAIT. A level already high on WAIT entry is accepted in the next cycle.
- Latency:
  - WAIT→ACCUM: 1 clk.
  - Last ACCUM → `lft`/`rht` valid: 2 clk (CALC_I, CALC_OUT).
  - Cycle length ≈ 3×SETTLE_CYCLES + 6×(conversion time + 3).

## Structure
- Package `motion_cntrl_pkg` holds:
  - the state enum;
  - the channel-sequence, weight and enable-select constant arrays;
  - the default parameter values;
  - a `sat` function (width-generic via separate sat11/sat12).
- One sub-module `pi_calc`: combinational Error/Intgrl/Pcomp/lft/rht math, registered in the parent FSM.

## Test plan
- Reset held, then released with go=0 → all outputs 0, no `start_conv` for 10000 clk.
- go=1, A2D_res=12'hAAA on all channels, instant `cnv_cmplt` → `chnnl` order 1,0,4,2,3,7; exactly one `start_conv` per channel; Accum=0; `LEDs`=0; `lft`=`rht`=11'h200.
- ch1 returns 12'h100, others 0 → Error=256, `LEDs`=8'h10, Intgrl=64, steer=1088; `lft`=11'h5C0 (−576), `rht`=11'h3FF (saturated).
- ch7 returns 12'hFFF, others 0 → Error sat12(−16380)=−2048, `LEDs`=8'h80; `lft`=11'h3FF, `rht`=11'h400.
- Repeat the ch1=12'h100 case for 40 cycles → Intgrl stops at 2047, never wraps.
- Drop go during a WAIT → IDLE next clock, enables 0, `lft`=`rht`=0. Re-raising go restarts at ch1 after SETTLE_CYCLES.
